// File: rtl/plic_claim_pkg.sv
// Shared types and default sizing for the PLIC claim/complete controller.
// The FSM walks IDLE -> CLAIM -> DISPATCH and then returns to IDLE.
package plic_claim_pkg;

    localparam int unsigned PLIC_NUM_SRC_DEF   = 32;
    localparam int unsigned PLIC_MAX_OUTST_DEF = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CLAIM    = 2'd1,
        DISPATCH = 2'd2
    } claim_state_e;

endpackage

// File: rtl/plic_claim_ctrl.sv
// Claims interrupt IDs from the PLIC, dispatches each one to a handler, and
// completes it once the handler reports done. Tracks outstanding IDs in a bitmap.
module plic_claim_ctrl
    import plic_claim_pkg::*;
#(
    parameter  int unsigned NumSrc   = PLIC_NUM_SRC_DEF,
    parameter  int unsigned MaxOutst = PLIC_MAX_OUTST_DEF,
    localparam int unsigned SrcW     = $clog2(NumSrc + 1),
    localparam int unsigned CntW     = $clog2(MaxOutst + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            irq_i,
    input  logic [SrcW-1:0] irq_id_i,
    output logic            claim_o,
    output logic [SrcW-1:0] claim_id_o,
    output logic            complete_o,
    output logic [SrcW-1:0] complete_id_o,
    output logic            disp_valid_o,
    output logic [SrcW-1:0] disp_id_o,
    input  logic            disp_ready_i,
    input  logic            done_valid_i,
    input  logic [SrcW-1:0] done_id_i,
    output logic            done_ready_o,
    output logic [CntW-1:0] outstanding_o,
    output logic            busy_o,
    output logic            err_o
);

    localparam logic [SrcW-1:0] MaxId  = SrcW'(NumSrc);
    localparam logic [CntW-1:0] MaxCnt = CntW'(MaxOutst);

    claim_state_e    r_state;
    claim_state_e    w_state_next;
    logic [SrcW-1:0] r_id;
    logic [SrcW-1:0] r_done_id;
    logic [NumSrc:0] r_claimed;
    logic [NumSrc:0] w_claimed_next;
    logic [NumSrc:0] w_set;
    logic [NumSrc:0] w_clr;
    logic [CntW-1:0] r_outst;
    logic            r_cmp_pend;
    logic            r_err;

    logic w_irq_free;
    logic w_claim_ok;
    logic w_accept;
    logic w_claim_exit;
    logic w_done_hit;
    logic w_complete;
    logic w_done_fire;

    // IDs above NumSrc cannot be represented in the bitmap and are never claimed.
    assign w_irq_free   = (irq_id_i != '0) && (irq_id_i <= MaxId) && !r_claimed[irq_id_i];
    assign w_claim_ok   = irq_i && w_irq_free && (r_outst < MaxCnt);
    assign w_accept     = (r_state == IDLE) && w_claim_ok;
    assign w_claim_exit = (r_state == CLAIM);

    // Bit 0 of the bitmap is tied low, so a done for ID 0 always reports an error.
    assign w_done_hit  = (r_done_id <= MaxId) && r_claimed[r_done_id];
    assign w_complete  = r_cmp_pend && w_done_hit;
    assign w_done_fire = done_valid_i && !r_cmp_pend;

    genvar gi;
    generate
        for (gi = 0; gi <= NumSrc; gi++) begin : g_claimed
            if (gi == 0) begin : g_zero
                assign w_set[gi]          = 1'b0;
                assign w_clr[gi]          = 1'b0;
                assign w_claimed_next[gi] = 1'b0;
            end else begin : g_bit
                assign w_set[gi]          = w_claim_exit && (r_id == SrcW'(gi));
                assign w_clr[gi]          = w_complete && (r_done_id == SrcW'(gi));
                assign w_claimed_next[gi] = (r_claimed[gi] && !w_clr[gi]) || w_set[gi];
            end
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= IDLE;
            r_id       <= '0;
            r_done_id  <= '0;
            r_claimed  <= '0;
            r_outst    <= '0;
            r_cmp_pend <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_claimed <= w_claimed_next;
            if (w_accept) begin
                r_id <= irq_id_i;
            end
            // A claim and a completion landing together cancel out.
            if (w_claim_exit && !w_complete) begin
                r_outst <= r_outst + 1'b1;
            end else if (!w_claim_exit && w_complete) begin
                r_outst <= r_outst - 1'b1;
            end
            if (w_done_fire) begin
                r_done_id <= done_id_i;
            end
            r_cmp_pend <= w_done_fire;
            if (r_cmp_pend && !w_done_hit) begin
                r_err <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        claim_o      = 1'b0;
        claim_id_o   = '0;
        disp_valid_o = 1'b0;
        disp_id_o    = '0;
        unique case (r_state)
            IDLE: begin
                if (w_claim_ok) begin
                    w_state_next = CLAIM;
                end
            end
            CLAIM: begin
                claim_o      = 1'b1;
                claim_id_o   = r_id;
                w_state_next = DISPATCH;
            end
            DISPATCH: begin
                disp_valid_o = 1'b1;
                disp_id_o    = r_id;
                if (disp_ready_i) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign complete_o    = w_complete;
    assign complete_id_o = w_complete ? r_done_id : '0;
    // Held low while reset is asserted so every output reads zero during reset.
    assign done_ready_o  = rst_ni && !r_cmp_pend;
    assign outstanding_o = r_outst;
    assign busy_o        = (r_state != IDLE);
    assign err_o         = r_err;

endmodule

// File: tb/tb_plic_claim_ctrl.sv
// Directed bench for plic_claim_ctrl: a transaction-level model checked every
// cycle, plus literal expectations at the interesting points.
module tb_plic_claim_ctrl;

    localparam int NUM_SRC   = 32;
    localparam int MAX_OUTST = 4;
    localparam int SRC_W     = $clog2(NUM_SRC + 1);
    localparam int CNT_W     = $clog2(MAX_OUTST + 1);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             irq = 1'b0;
    logic [SRC_W-1:0] irq_id = '0;
    logic             claim;
    logic [SRC_W-1:0] claim_id;
    logic             complete;
    logic [SRC_W-1:0] complete_id;
    logic             disp_valid;
    logic [SRC_W-1:0] disp_id;
    logic             disp_ready = 1'b0;
    logic             done_valid = 1'b0;
    logic [SRC_W-1:0] done_id = '0;
    logic             done_ready;
    logic [CNT_W-1:0] outstanding;
    logic             busy;
    logic             err;

    plic_claim_ctrl #(.NumSrc(NUM_SRC), .MaxOutst(MAX_OUTST)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .irq_i         (irq),
        .irq_id_i      (irq_id),
        .claim_o       (claim),
        .claim_id_o    (claim_id),
        .complete_o    (complete),
        .complete_id_o (complete_id),
        .disp_valid_o  (disp_valid),
        .disp_id_o     (disp_id),
        .disp_ready_i  (disp_ready),
        .done_valid_i  (done_valid),
        .done_id_i     (done_id),
        .done_ready_o  (done_ready),
        .outstanding_o (outstanding),
        .busy_o        (busy),
        .err_o         (err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: one in-flight ID (0 = none) that is announced once then offered
    // until accepted; a set of owned IDs; one pending done ID (-1 = none).
    int m_inflight = 0;
    bit m_announced = 1'b0;
    bit m_owned[int];
    int m_pend = -1;
    bit m_err = 1'b0;

    always @(posedge clk or negedge rst_n) begin : model_upd
        bit cmp_hit;
        bit can_acc;
        bit fire;
        if (!rst_n) begin
            m_inflight  = 0;
            m_announced = 1'b0;
            m_owned.delete();
            m_pend      = -1;
            m_err       = 1'b0;
        end else begin
            cmp_hit = (m_pend >= 0) && m_owned.exists(m_pend);
            can_acc = (m_inflight == 0) && irq && (int'(irq_id) != 0) &&
                      (int'(irq_id) <= NUM_SRC) && (m_owned.num() < MAX_OUTST) &&
                      !m_owned.exists(int'(irq_id));
            fire    = done_valid && (m_pend < 0);
            if (m_pend >= 0) begin
                if (cmp_hit) m_owned.delete(m_pend);
                else m_err = 1'b1;
                m_pend = -1;
            end
            if (m_inflight != 0 && !m_announced) begin
                m_owned[m_inflight] = 1'b1;
                m_announced = 1'b1;
            end else if (m_inflight != 0 && disp_ready) begin
                m_inflight = 0;
            end else if (can_acc) begin
                m_inflight  = int'(irq_id);
                m_announced = 1'b0;
            end
            if (fire) m_pend = int'(done_id);
        end
    end

    always @(negedge clk) begin : compare
        bit e_claim;
        bit e_disp;
        bit e_cmp;
        if (!rst_n) begin
            chk("rst claim_o", int'(claim), 0);
            chk("rst disp_valid_o", int'(disp_valid), 0);
            chk("rst complete_o", int'(complete), 0);
            chk("rst done_ready_o", int'(done_ready), 0);
            chk("rst outstanding_o", int'(outstanding), 0);
            chk("rst busy_o", int'(busy), 0);
            chk("rst err_o", int'(err), 0);
        end else begin
            e_claim = (m_inflight != 0) && !m_announced;
            e_disp  = (m_inflight != 0) && m_announced;
            e_cmp   = (m_pend >= 0) && m_owned.exists(m_pend);
            chk("claim_o", int'(claim), int'(e_claim));
            chk("claim_id_o", int'(claim_id), e_claim ? m_inflight : 0);
            chk("disp_valid_o", int'(disp_valid), int'(e_disp));
            chk("disp_id_o", int'(disp_id), e_disp ? m_inflight : 0);
            chk("complete_o", int'(complete), int'(e_cmp));
            chk("complete_id_o", int'(complete_id), e_cmp ? m_pend : 0);
            chk("done_ready_o", int'(done_ready), int'(m_pend < 0));
            chk("outstanding_o", int'(outstanding), m_owned.num());
            chk("busy_o", int'(busy), int'(m_inflight != 0));
            chk("err_o", int'(err), int'(m_err));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "simulation did not finish in time");
    end

    initial begin : stim
        repeat (3) tick();
        chk("lit reset outstanding", int'(outstanding), 0);
        rst_n = 1'b1;

        // Single claim, dispatch and complete of ID 5.
        irq = 1'b1; irq_id = 6'd5; disp_ready = 1'b1;
        tick();
        chk("lit A claim_o", int'(claim), 1);
        chk("lit A claim_id", int'(claim_id), 5);
        tick();
        chk("lit A disp_valid", int'(disp_valid), 1);
        chk("lit A disp_id", int'(disp_id), 5);
        chk("lit A outstanding", int'(outstanding), 1);
        irq = 1'b0;
        tick();
        done_valid = 1'b1; done_id = 6'd5;
        tick();
        chk("lit B complete_o", int'(complete), 1);
        chk("lit B complete_id", int'(complete_id), 5);
        done_valid = 1'b0;
        tick();
        chk("lit B outstanding", int'(outstanding), 0);
        chk("lit B err", int'(err), 0);

        // Fill to MaxOutst, then a fifth request must wait for a completion.
        for (int k = 1; k <= 4; k++) begin
            irq = 1'b1; irq_id = SRC_W'(k);
            repeat (3) tick();
        end
        chk("lit C outstanding full", int'(outstanding), 4);
        irq_id = 6'd6;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("lit C no fifth claim", int'(claim), 0);
        end
        done_valid = 1'b1; done_id = 6'd2;
        tick();
        chk("lit C complete_id 2", int'(complete_id), 2);
        done_valid = 1'b0;
        tick();
        chk("lit C outstanding 3", int'(outstanding), 3);
        tick();
        chk("lit C claim 6", int'(claim_id), 6);
        irq = 1'b0;
        repeat (2) tick();

        // Done for IDs never claimed: no completion, sticky error.
        done_valid = 1'b1; done_id = 6'd7;
        tick();
        chk("lit D no complete 7", int'(complete), 0);
        done_valid = 1'b0;
        tick();
        chk("lit D err after 7", int'(err), 1);
        done_valid = 1'b1; done_id = 6'd0;
        tick();
        chk("lit D no complete 0", int'(complete), 0);
        done_valid = 1'b0;
        tick();
        chk("lit D err stays", int'(err), 1);

        // Back-to-back dones with valid held high: accepted every other cycle.
        done_valid = 1'b1; done_id = 6'd1;
        tick();
        chk("lit D complete 1", int'(complete_id), 1);
        done_id = 6'd3;
        tick();
        chk("lit D gap cycle", int'(complete), 0);
        tick();
        chk("lit D complete 3", int'(complete_id), 3);
        done_id = 6'd4;
        repeat (2) tick();
        chk("lit D complete 4", int'(complete_id), 4);
        done_id = 6'd6;
        repeat (2) tick();
        chk("lit D complete 6", int'(complete_id), 6);
        done_valid = 1'b0;
        tick();
        chk("lit D drained", int'(outstanding), 0);

        // Dispatch stall: output held, no new claim, done during stall completes.
        disp_ready = 1'b0; irq = 1'b1; irq_id = 6'd9;
        tick();
        chk("lit E claim 9", int'(claim_id), 9);
        irq_id = 6'd10;
        tick();
        for (int i = 0; i < 10; i++) begin
            chk("lit E disp_valid held", int'(disp_valid), 1);
            chk("lit E disp_id held", int'(disp_id), 9);
            chk("lit E no claim", int'(claim), 0);
            if (i == 2) begin
                done_valid = 1'b1; done_id = 6'd9;
            end
            if (i == 3) begin
                chk("lit E complete 9", int'(complete_id), 9);
                done_valid = 1'b0;
            end
            tick();
        end
        chk("lit E outstanding", int'(outstanding), 0);
        disp_ready = 1'b1;
        tick();
        chk("lit E idle", int'(busy), 0);
        tick();
        chk("lit E claim 10", int'(claim_id), 10);
        irq = 1'b0;
        repeat (2) tick();
        done_valid = 1'b1; done_id = 6'd10;
        tick();
        done_valid = 1'b0;
        tick();

        // Reset mid-dispatch and mid-completion with two outstanding.
        irq = 1'b1; irq_id = 6'd11;
        repeat (3) tick();
        disp_ready = 1'b0; irq_id = 6'd12;
        repeat (2) tick();
        irq = 1'b0;
        chk("lit F outstanding 2", int'(outstanding), 2);
        done_valid = 1'b1; done_id = 6'd11;
        tick();
        chk("lit F completing", int'(complete), 1);
        done_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("lit F rst claim", int'(claim), 0);
        chk("lit F rst disp_valid", int'(disp_valid), 0);
        chk("lit F rst disp_id", int'(disp_id), 0);
        chk("lit F rst complete", int'(complete), 0);
        chk("lit F rst complete_id", int'(complete_id), 0);
        chk("lit F rst done_ready", int'(done_ready), 0);
        chk("lit F rst outstanding", int'(outstanding), 0);
        chk("lit F rst busy", int'(busy), 0);
        chk("lit F rst err", int'(err), 0);
        repeat (2) tick();
        rst_n = 1'b1; disp_ready = 1'b1;
        tick();
        chk("lit F post outstanding", int'(outstanding), 0);
        chk("lit F post err", int'(err), 0);
        irq = 1'b1; irq_id = 6'd12;
        tick();
        chk("lit F reclaim 12", int'(claim_id), 12);
        irq = 1'b0;
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
